// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
// The slave side is the adder; the master side is whoever feeds it and drains it.
interface cla_pipe_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;
   logic             out_zero;

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
   );

   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
   );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit CLA group per stage,
// group carry and the untouched operand bits registered into the next stage.
module cla_pipe_adder #(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   cla_pipe_adder_if.slave   io
);
   localparam int NSTG = WIDTH / BLOCK;

   // Flattened lookahead: every carry is a sum of generate/propagate products.
   function automatic logic [BLOCK:0] cla_carries(input logic [BLOCK-1:0] g,
                                                  input logic [BLOCK-1:0] p,
                                                  input logic             c0);
      logic [BLOCK:0] c;
      logic           term;
      c    = '0;
      c[0] = c0;
      for (int i = 0; i < BLOCK; i++) begin
         for (int j = 0; j <= i + 1; j++) begin
            term = (j == 0) ? c0 : g[j-1];
            for (int m = j; m <= i; m++) term = term & p[m];
            c[i+1] = c[i+1] | term;
         end
      end
      return c;
   endfunction

   logic             stall;
   logic             accept;
   logic [WIDTH-1:0] b_mux;
   logic             c_mux;

   logic             vld_q [NSTG];
   logic             vld_d [NSTG];
   logic [WIDTH-1:0] a_q   [NSTG];
   logic [WIDTH-1:0] a_d   [NSTG];
   logic [WIDTH-1:0] b_q   [NSTG];
   logic [WIDTH-1:0] b_d   [NSTG];
   logic [WIDTH-1:0] sum_q [NSTG];
   logic [WIDTH-1:0] sum_d [NSTG];
   logic             cry_q [NSTG];
   logic             cry_d [NSTG];
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   assign stall       = vld_q[NSTG-1] & ~io.out_ready;
   assign io.in_ready = ~stall;
   assign accept      = io.in_valid & ~stall;
   assign b_mux       = io.in_sub ? ~io.in_b : io.in_b;
   assign c_mux       = io.in_sub | io.in_cin;

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      localparam int LO = k * BLOCK;
      logic [WIDTH-1:0] src_a, src_b, src_sum;
      logic             src_c, src_v;
      logic [BLOCK-1:0] g, p;
      logic [BLOCK:0]   c;

      if (k == 0) begin : g_first
         assign src_a   = io.in_a;
         assign src_b   = b_mux;
         assign src_c   = c_mux;
         assign src_v   = accept;
         assign src_sum = '0;
      end else begin : g_next
         assign src_a   = a_q[k-1];
         assign src_b   = b_q[k-1];
         assign src_c   = cry_q[k-1];
         assign src_v   = vld_q[k-1];
         assign src_sum = sum_q[k-1];
      end

      assign g = src_a[LO +: BLOCK] & src_b[LO +: BLOCK];
      assign p = src_a[LO +: BLOCK] ^ src_b[LO +: BLOCK];
      assign c = cla_carries(g, p, src_c);

      // Bits at and above LO are still zero in the accumulated sum.
      assign sum_d[k] = src_sum | (WIDTH'(p ^ c[BLOCK-1:0]) << LO);
      assign cry_d[k] = c[BLOCK];
      assign vld_d[k] = src_v;
      assign a_d[k]   = src_a;
      assign b_d[k]   = src_b;

      if (k == NSTG - 1) begin : g_last
         assign ovf_d  = c[BLOCK-1] ^ c[BLOCK];
         assign zero_d = (sum_d[k] == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NSTG; k++) vld_q[k] <= 1'b0;
         sum_q[NSTG-1] <= '0;
         cry_q[NSTG-1] <= 1'b0;
         ovf_q         <= 1'b0;
         zero_q        <= 1'b1;
      end else if (!stall) begin
         for (int k = 0; k < NSTG; k++) begin
            vld_q[k] <= vld_d[k];
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sum_q[k] <= sum_d[k];
            cry_q[k] <= cry_d[k];
         end
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign io.out_valid = vld_q[NSTG-1];
   assign io.out_sum   = sum_q[NSTG-1];
   assign io.out_cout  = cry_q[NSTG-1];
   assign io.out_ovf   = ovf_q;
   assign io.out_zero  = zero_q;
endmodule
